// File: rtl/zapper_pkg.sv
// zapper_pkg: shared state, flash-mode encodings and video geometry for the zapper shot sequencer
package zapper_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        BLACK,
        TARGET,
        HOLD
    } zap_state_t;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_BLACK  = 2'd1,
        MODE_TARGET = 2'd2
    } flash_mode_t;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

endpackage

// File: rtl/zapper_flash_ctrl_if.sv
// zapper_flash_ctrl_if: VGA timing, zapper pins and pattern-generator control bundled for the shot sequencer
interface zapper_flash_ctrl_if;
    import zapper_pkg::*;

    logic        valid;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        trigger;
    logic        sensor;
    flash_mode_t flash_mode;
    logic        busy;
    logic        hit;
    logic        miss;

    modport master (
        output valid, col, row, trigger, sensor,
        input  flash_mode, busy, hit, miss
    );

    modport slave (
        input  valid, col, row, trigger, sensor,
        output flash_mode, busy, hit, miss
    );

endinterface

// File: rtl/sync_edge.sv
// sync_edge: 2-FF synchronizer for an asynchronous pin with a rising-edge pulse on the synchronized level
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two capture stages for metastability, plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/zapper_flash_ctrl.sv
// zapper_flash_ctrl: Duck Hunt zapper shot sequencer (black frames, target frames, light-count verdict); ZAPPER_ANTI_CHEAT_EN also samples black frames and vetoes a lit sensor
module zapper_flash_ctrl #(
    parameter int unsigned BLACK_FRAMES      = 1,
    parameter int unsigned TARGET_FRAMES     = 1,
    parameter int unsigned HIT_THRESH        = 64,
    parameter bit          SENSOR_ACTIVE_LOW = 1'b1
) (
    input logic clk,
    input logic reset,
    zapper_flash_ctrl_if.slave bus
);
    import zapper_pkg::*;

    logic        trig_s;
    logic        trig_rise;
    logic        sen_s;
    logic        sen_rise_unused;
    logic        sensor_lit;
    logic        pixel_lit;
    logic        frame_start;
    logic        black_last;
    logic        target_last;
    logic        cheat;
    logic        verdict;
    zap_state_t  state_q, state_d;
    logic [3:0]  frame_cnt_q, frame_cnt_d;
    logic [15:0] lit_cnt_q, lit_cnt_d;
    logic        hit_q, hit_d;
    logic        miss_q, miss_d;

    sync_edge u_trig_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (bus.trigger),
        .q_o    (trig_s),
        .rise_o (trig_rise)
    );

    sync_edge u_sen_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (bus.sensor),
        .q_o    (sen_s),
        .rise_o (sen_rise_unused)
    );

    assign sensor_lit  = sen_s ^ SENSOR_ACTIVE_LOW;
    assign pixel_lit   = bus.valid & sensor_lit;
    assign frame_start = (bus.col == 10'd0) && (bus.row == 10'd0);
    assign black_last  = frame_cnt_q == 4'(BLACK_FRAMES - 1);
    assign target_last = frame_cnt_q == 4'(TARGET_FRAMES - 1);
    assign verdict     = !cheat && (lit_cnt_q >= 16'(HIT_THRESH));

`ifdef ZAPPER_ANTI_CHEAT_EN
    logic [15:0] dark_cnt_q, dark_cnt_d;
    logic        cheat_q, cheat_d;

    // Count light seen while the screen is black; too much of it means the gun is aimed at a lamp
    always_comb begin
        dark_cnt_d = dark_cnt_q;
        cheat_d    = cheat_q;
        if (state_q == IDLE && trig_rise) cheat_d = 1'b0;
        if (state_q == ARMED && frame_start) dark_cnt_d = '0;
        if (state_q == BLACK) begin
            if (pixel_lit && dark_cnt_q != 16'hFFFF) dark_cnt_d = dark_cnt_q + 16'd1;
            if (frame_start && black_last) cheat_d = dark_cnt_q >= 16'(HIT_THRESH);
        end
    end

    // Anti-cheat state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            dark_cnt_q <= '0;
            cheat_q    <= 1'b0;
        end else begin
            dark_cnt_q <= dark_cnt_d;
            cheat_q    <= cheat_d;
        end
    end

    assign cheat = cheat_q;
`else
    assign cheat = 1'b0;
`endif

    // Shot sequencing: frame-aligned black/target phases, then one verdict pulse as HOLD is entered
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        lit_cnt_d   = lit_cnt_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        unique case (state_q)
            IDLE: if (trig_rise) state_d = ARMED;
            ARMED: begin
                if (frame_start) begin
                    state_d     = BLACK;
                    frame_cnt_d = '0;
                    lit_cnt_d   = '0;
                end
            end
            BLACK: begin
                if (frame_start && black_last) begin
                    state_d     = TARGET;
                    frame_cnt_d = '0;
                    lit_cnt_d   = '0;
                end else if (frame_start) begin
                    frame_cnt_d = frame_cnt_q + 4'd1;
                end
            end
            TARGET: begin
                if (pixel_lit && lit_cnt_q != 16'hFFFF) lit_cnt_d = lit_cnt_q + 16'd1;
                if (frame_start && target_last) begin
                    state_d = HOLD;
                    hit_d   = verdict;
                    miss_d  = !verdict;
                end else if (frame_start) begin
                    frame_cnt_d = frame_cnt_q + 4'd1;
                end
            end
            HOLD: if (!trig_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counters and verdict pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            lit_cnt_q   <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            lit_cnt_q   <= lit_cnt_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
        end
    end

    assign bus.flash_mode = (state_q == BLACK)  ? MODE_BLACK  :
                            (state_q == TARGET) ? MODE_TARGET : MODE_NORMAL;
    assign bus.busy       = state_q != IDLE;
    assign bus.hit        = hit_q;
    assign bus.miss       = miss_q;

endmodule

// File: tb/tb_zapper_flash_ctrl.sv
// tb_zapper_flash_ctrl: directed table of shots with hand-computed verdicts plus multi-cycle corner sequences
module tb_zapper_flash_ctrl;
    import zapper_pkg::*;

    localparam int TB_COLS  = H_ACTIVE / 4;
    localparam int TB_ROWS  = V_ACTIVE / 240;
    localparam int ACT_COLS = TB_COLS - 20;
    localparam int FRAME    = TB_COLS * TB_ROWS;
    localparam logic LIT    = 1'b0;
    localparam logic DARK   = 1'b1;

    typedef struct {
        int   lit_n;
        logic exp_hit;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic trigger = 1'b0;
    logic sensor = DARK;
    logic [9:0] tb_col = '0;
    logic [9:0] tb_row = '0;
    int n_vec = 0;
    int n_bad = 0;
    int hit_seen = 0;
    int miss_seen = 0;
    int both_seen = 0;
    vec_t vecs [6];

    zapper_flash_ctrl_if bus ();

    assign bus.col     = tb_col;
    assign bus.row     = tb_row;
    assign bus.valid   = (tb_row == 10'd0) && (tb_col < 10'(ACT_COLS));
    assign bus.trigger = trigger;
    assign bus.sensor  = sensor;

    zapper_flash_ctrl #(
        .BLACK_FRAMES      (1),
        .TARGET_FRAMES     (1),
        .HIT_THRESH        (64),
        .SENSOR_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tb_col <= (tb_col == 10'(TB_COLS - 1)) ? 10'd0 : tb_col + 10'd1;
        if (tb_col == 10'(TB_COLS - 1)) tb_row <= (tb_row == 10'(TB_ROWS - 1)) ? 10'd0 : tb_row + 10'd1;
    end

    always @(negedge clk) begin
        if (bus.hit === 1'b1) hit_seen++;
        if (bus.miss === 1'b1) miss_seen++;
        if (bus.hit === 1'b1 && bus.miss === 1'b1) both_seen++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_at(input int r, input int c);
        int n = 0;
        while (!(tb_row == 10'(r) && tb_col == 10'(c)) && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_mode(input flash_mode_t m, input string tag);
        int n = 0;
        while (bus.flash_mode !== m && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_mode_reached"}, 32'(bus.flash_mode), 32'(m));
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int n = 0;
        while (bus.busy !== lvl && n < 6 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_reached"}, 32'(bus.busy), 32'(lvl));
    endtask

    task automatic press_release(input string tag);
        wait_at(1, 20);
        trigger = 1'b1;
        repeat (6) @(negedge clk);
        check({tag, "_armed_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_armed_mode"}, 32'(bus.flash_mode), 32'(MODE_NORMAL));
        trigger = 1'b0;
    endtask

    task automatic shot(input int lit_n, input logic exp_hit, input string tag);
        int h0, m0, bl, tg;
        h0 = hit_seen;
        m0 = miss_seen;
        press_release(tag);
        wait_mode(MODE_BLACK, tag);
        bl = 0;
        while (bus.flash_mode === MODE_BLACK && bl < 2 * FRAME) begin
            bl++;
            @(negedge clk);
        end
        check({tag, "_black_len"}, 32'(bl), 32'(FRAME));
        tg = 0;
        while (bus.flash_mode === MODE_TARGET && tg < 2 * FRAME) begin
            sensor = (tb_row == 10'd0 && tb_col >= 10'd10 && 32'(tb_col) < 10 + lit_n) ? LIT : DARK;
            tg++;
            @(negedge clk);
        end
        sensor = DARK;
        check({tag, "_target_len"}, 32'(tg), 32'(FRAME));
        check({tag, "_hit_pulse"}, 32'(bus.hit), 32'(exp_hit));
        check({tag, "_miss_pulse"}, 32'(bus.miss), 32'(!exp_hit));
        repeat (4) @(negedge clk);
        check({tag, "_hit_count"}, 32'(hit_seen - h0), 32'(exp_hit));
        check({tag, "_miss_count"}, 32'(miss_seen - m0), 32'(!exp_hit));
        check({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int h0, m0, quiet, cnt;
        vecs[0] = '{100, 1'b1};
        vecs[1] = '{63, 1'b0};
        vecs[2] = '{64, 1'b1};
        vecs[3] = '{0, 1'b0};
        vecs[4] = '{120, 1'b1};
        vecs[5] = '{65, 1'b1};

        repeat (3) @(negedge clk);
        check("reset_mode", 32'(bus.flash_mode), 32'(MODE_NORMAL));
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_hit", 32'(bus.hit), 32'd0);
        check("reset_miss", 32'(bus.miss), 32'd0);
        reset = 1'b0;
        quiet = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (bus.flash_mode !== MODE_NORMAL || bus.busy !== 1'b0 || bus.hit !== 1'b0 || bus.miss !== 1'b0) quiet++;
        end
        check("idle_quiet", 32'(quiet), 32'd0);

        for (int i = 0; i < 6; i++) shot(vecs[i].lit_n, vecs[i].exp_hit, $sformatf("vec%0d_lit%0d", i, vecs[i].lit_n));

        h0 = hit_seen;
        m0 = miss_seen;
        press_release("retrig");
        wait_mode(MODE_BLACK, "retrig");
        repeat (50) @(negedge clk);
        trigger = 1'b1;
        wait_mode(MODE_TARGET, "retrig");
        while (bus.flash_mode === MODE_TARGET) @(negedge clk);
        quiet = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (bus.busy !== 1'b1 || bus.flash_mode !== MODE_NORMAL) quiet++;
        end
        check("retrig_hold_stays", 32'(quiet), 32'd0);
        check("retrig_one_verdict", 32'((hit_seen - h0) + (miss_seen - m0)), 32'd1);
        trigger = 1'b0;
        repeat (5) @(negedge clk);
        check("retrig_release_idle", 32'(bus.busy), 32'd0);
        press_release("retrig2");
        wait_mode(MODE_BLACK, "retrig2");
        wait_busy(1'b0, "retrig2");
        check("retrig_two_verdicts", 32'((hit_seen - h0) + (miss_seen - m0)), 32'd2);

        h0 = hit_seen;
        m0 = miss_seen;
        wait_at(1, 158);
        trigger = 1'b1;
        cnt = 0;
        while (bus.flash_mode !== MODE_BLACK && cnt < 4 * FRAME) begin
            @(negedge clk);
            cnt++;
        end
        check("coincide_black_delay", 32'(cnt), 32'(FRAME + 3));
        trigger = 1'b0;
        wait_busy(1'b0, "coincide");
        check("coincide_miss", 32'(miss_seen - m0), 32'd1);
        check("coincide_no_hit", 32'(hit_seen - h0), 32'd0);

        h0 = hit_seen;
        m0 = miss_seen;
        press_release("abort");
        wait_mode(MODE_TARGET, "abort");
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_mode", 32'(bus.flash_mode), 32'(MODE_NORMAL));
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_hit", 32'(bus.hit), 32'd0);
        check("abort_miss", 32'(bus.miss), 32'd0);
        reset = 1'b0;
        repeat (2 * FRAME) @(negedge clk);
        check("abort_no_verdict", 32'((hit_seen - h0) + (miss_seen - m0)), 32'd0);
        check("abort_still_idle", 32'(bus.busy), 32'd0);

        h0 = hit_seen;
        m0 = miss_seen;
        sensor = LIT;
        press_release("lamp");
        wait_busy(1'b0, "lamp");
        sensor = DARK;
`ifdef ZAPPER_ANTI_CHEAT_EN
        check("lamp_miss", 32'(miss_seen - m0), 32'd1);
        check("lamp_no_hit", 32'(hit_seen - h0), 32'd0);
`else
        check("lamp_hit", 32'(hit_seen - h0), 32'd1);
        check("lamp_no_miss", 32'(miss_seen - m0), 32'd0);
`endif

        check("never_both", 32'(both_seen), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/zapper_flash_ctrl.md
Name: zapper_flash_ctrl

Overview:
- Sequences the Duck Hunt zapper shot.
- On a trigger press it forces the pattern generator through frame-aligned black and target-flash frames, then samples the zapper light sensor and reports hit or miss.
- Sits between the zapper input pins and the pattern generator; it consumes the VGA timing outputs col, row and valid.
- Drives the flash_mode input of the pattern generator.

Parameters:
- BLACK_FRAMES, 1, number of full frames held in MODE_BLACK (1..15).
- TARGET_FRAMES, 1, number of full frames held in MODE_TARGET (1..15).
- HIT_THRESH, 64, lit-pixel count at or above which a frame is declared "light seen" (16-bit).
- SENSOR_ACTIVE_LOW, 1, 1 = raw sensor pin is low when light is detected.

Ports:
- clk, input, 1, pixel clock; the same clock as the VGA timing generator.
- reset, input, 1, synchronous, active-high.
- valid, input, 1, active video region.
- col, input, 10, current column.
- row, input, 10, current row.
- trigger, input, 1, raw zapper trigger, asynchronous, active-high.
- sensor, input, 1, raw zapper photodiode, asynchronous; polarity set by SENSOR_ACTIVE_LOW.
- flash_mode, output, 2, 0 = NORMAL, 1 = BLACK, 2 = TARGET.
- busy, output, 1, high in any state other than IDLE.
- hit, output, 1, one-cycle pulse: shot hit.
- miss, output, 1, one-cycle pulse: shot missed.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Input synchronisation:
  - trigger and sensor each pass through a 2-FF synchronizer.
  - The trigger rising edge (trig_rise) is detected on the synchronized signal.
  - sensor_lit = synchronized sensor XOR SENSOR_ACTIVE_LOW.
- frame_start: one-cycle pulse when col==0 && row==0.
- State machine (state register, plus frame_cnt[3:0] and lit_cnt[15:0]):
  - IDLE: on trig_rise, go to ARMED.
  - ARMED: on frame_start, go to BLACK; frame_cnt=0, lit_cnt=0.
  - BLACK: on frame_start, frame_cnt++. When frame_cnt==BLACK_FRAMES-1, go to TARGET; frame_cnt=0, lit_cnt=0.
  - TARGET: each cycle with valid && sensor_lit, lit_cnt++, saturating at 16'hFFFF. On frame_start with frame_cnt==TARGET_FRAMES-1, go to HOLD and register verdict = (lit_cnt >= HIT_THRESH).
  - HOLD: when synchronized trigger==0, go to IDLE.
- Outputs:
  - flash_mode is decoded from the state register: BLACK gives 1, TARGET gives 2, all other states give 0.
  - flash_mode therefore changes in the cycle after the frame_start cycle that caused the transition.
  - hit or miss pulses exactly one cycle, in the cycle after the TARGET->HOLD transition. Never both; exactly one per shot.
  - busy = (state != IDLE).
- Latency: a trigger edge at the pin causes trig_rise 3 cycles later. Then ARMED lasts until the next frame_start.
- Boundary conditions:
  - trig_rise in ARMED, BLACK, TARGET or HOLD is ignored; no queued shot.
  - Trigger released during ARMED, BLACK or TARGET: the shot completes normally.
  - Trigger still held at HOLD entry: no new shot until it is released and pressed again.
  - trig_rise coincident with frame_start in IDLE: go to ARMED only. BLACK starts at the following frame_start.
  - lit_cnt saturates; it never wraps.
- Reset:
  - reset at any time forces IDLE, flash_mode=0, busy=0, hit=miss=0 and clears all counters and synchronizers.
  - No verdict is emitted for an aborted shot.

Optional Feature:
- Macro: ZAPPER_ANTI_CHEAT_EN.
- Defined:
  - lit_cnt also accumulates during BLACK frames into dark_cnt[15:0] (saturating).
  - If dark_cnt >= HIT_THRESH at BLACK exit, a cheat flag is set. This covers a sensor pointed at a lamp.
  - A set cheat flag forces the verdict to miss regardless of the TARGET count.
  - The flag clears on entry to ARMED.
- Undefined: BLACK frames are not sampled; the verdict depends only on the TARGET count.

Decomposition:
- Package zapper_pkg holds:
  - typedef zap_state_t {IDLE, ARMED, BLACK, TARGET, HOLD};
  - typedef flash_mode_t (2 bits) with constants MODE_NORMAL=0, MODE_BLACK=1, MODE_TARGET=2;
  - localparam H_ACTIVE=640, V_ACTIVE=480.
- One sub-module, sync_edge: 2-FF synchronizer with a rising-edge pulse output and reset. It is instantiated twice; the edge output is unused for sensor.

Test Plan:
- Reset, then idle for 2 frames: flash_mode=0, busy=0, hit=miss=0 throughout.
- Trigger pulse mid-frame, sensor lit for 100 active pixels of the TARGET frame (HIT_THRESH=64): flash_mode 1 for one frame then 2 for one frame, then one hit pulse; miss never asserts.
- Same stimulus with only 63 lit pixels: exactly one miss pulse; count 64 gives hit (threshold boundary).
- Second trigger edge during BLACK, with trigger held through HOLD: no second shot. Release and press again: a new ARMED sequence starts.
- reset asserted during TARGET: next cycle flash_mode=0, busy=0, and no hit or miss pulse for that shot.
- With ZAPPER_ANTI_CHEAT_EN defined, sensor lit continuously through BLACK and TARGET: miss pulse. Undefined, same stimulus: hit pulse.
